// File: rtl/sine_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sine_pkg                                                                 |
// | Width derivations and constants shared by the sine generators/meter.    |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
package sine_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } meter_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int chan_width(input int nr_channels);
    return clog2_min1(nr_channels);
  endfunction

  function automatic int freq_width(input int sample_frequency);
    return $clog2(sample_frequency / 2) + 1;
  endfunction

  function automatic longint full_scale(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  // Bits carried by one sample beat: data, channel and valid.
  function automatic int stream_width(input int input_width, input int nr_channels);
    return input_width + chan_width(nr_channels) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_wave_meter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sine_wave_meter                                                          |
// | Per-channel frequency (hysteresis zero crossings) and peak meter.       |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module sine_wave_meter
  import sine_pkg::*;
#(
  parameter int NR_CHANNELS      = 2,
  parameter int INPUT_WIDTH      = 24,
  parameter int SAMPLE_FREQUENCY = 48000,
  parameter int WINDOW_SAMPLES   = 4800,
  parameter int HYSTERESIS       = 256,
  localparam int CHANNEL_WIDTH   = chan_width(NR_CHANNELS),
  localparam int FREQUENCY_WIDTH = freq_width(SAMPLE_FREQUENCY)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INPUT_WIDTH-1:0]     s_sm_d,
  input  logic [CHANNEL_WIDTH-1:0]   s_sm_ch,
  input  logic                       s_sm_dv,
  output logic                       s_sm_dr,
  output logic [FREQUENCY_WIDTH-1:0] m_fm_f,
  output logic [INPUT_WIDTH-2:0]     m_fm_peak,
  output logic [CHANNEL_WIDTH-1:0]   m_fm_ch,
  output logic                       m_fm_dv,
  input  logic                       m_fm_dr
);

  localparam int COUNT_WIDTH = clog2_min1(WINDOW_SAMPLES);
  localparam int CROSS_WIDTH = clog2_min1(WINDOW_SAMPLES / 2 + 1);
  localparam logic [COUNT_WIDTH-1:0]     COUNT_LAST = COUNT_WIDTH'(WINDOW_SAMPLES - 1);
  localparam logic [COUNT_WIDTH-1:0]     COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [CROSS_WIDTH-1:0]     CROSS_ONE  = CROSS_WIDTH'(1);
  localparam logic [CROSS_WIDTH-1:0]     CROSS_MAX  = '1;
  localparam logic [INPUT_WIDTH-2:0]     ABS_ONE    = (INPUT_WIDTH-1)'(1);
  localparam logic [INPUT_WIDTH-2:0]     PEAK_FULL  = (INPUT_WIDTH-1)'(full_scale(INPUT_WIDTH));
  localparam logic [FREQUENCY_WIDTH-1:0] RATIO      = FREQUENCY_WIDTH'(SAMPLE_FREQUENCY / WINDOW_SAMPLES);
  localparam logic signed [INPUT_WIDTH-1:0] NEG_HYST = INPUT_WIDTH'(-HYSTERESIS);
  localparam logic [CHANNEL_WIDTH:0]     NR_CH      = (CHANNEL_WIDTH+1)'(NR_CHANNELS);

  if ((SAMPLE_FREQUENCY % WINDOW_SAMPLES) != 0 || HYSTERESIS <= 0 ||
      longint'(HYSTERESIS) > full_scale(INPUT_WIDTH)) begin : g_param_check
    $fatal(1, "sine_wave_meter: illegal WINDOW_SAMPLES or HYSTERESIS");
  end

  meter_state_e                state_q, state_d;
  logic                        s_sm_dr_q, s_sm_dr_d;
  logic signed [INPUT_WIDTH-1:0] sample_q, sample_d;
  logic [CHANNEL_WIDTH-1:0]    chan_q, chan_d;
  logic [FREQUENCY_WIDTH-1:0]  m_fm_f_q, m_fm_f_d;
  logic [INPUT_WIDTH-2:0]      m_fm_peak_q, m_fm_peak_d;
  logic [CHANNEL_WIDTH-1:0]    m_fm_ch_q, m_fm_ch_d;
  logic                        m_fm_dv_q, m_fm_dv_d;

  logic                        armed_q [NR_CHANNELS];
  logic                        armed_d [NR_CHANNELS];
  logic [CROSS_WIDTH-1:0]      cross_q [NR_CHANNELS];
  logic [CROSS_WIDTH-1:0]      cross_d [NR_CHANNELS];
  logic [COUNT_WIDTH-1:0]      count_q [NR_CHANNELS];
  logic [COUNT_WIDTH-1:0]      count_d [NR_CHANNELS];
  logic [INPUT_WIDTH-2:0]      peak_q  [NR_CHANNELS];
  logic [INPUT_WIDTH-2:0]      peak_d  [NR_CHANNELS];

  logic                        x_is_min;
  logic [INPUT_WIDTH-2:0]      abs_val;
  logic [INPUT_WIDTH-2:0]      peak_new;
  logic [CROSS_WIDTH-1:0]      cross_new;
  logic                        armed_new;

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    chan_d      = chan_q;
    m_fm_f_d    = m_fm_f_q;
    m_fm_peak_d = m_fm_peak_q;
    m_fm_ch_d   = m_fm_ch_q;
    m_fm_dv_d   = m_fm_dv_q;
    armed_d     = armed_q;
    cross_d     = cross_q;
    count_d     = count_q;
    peak_d      = peak_q;

    // The most negative code has no positive twin; clamp it to full scale.
    x_is_min  = sample_q[INPUT_WIDTH-1] & ~(|sample_q[INPUT_WIDTH-2:0]);
    abs_val   = x_is_min ? PEAK_FULL :
                (sample_q[INPUT_WIDTH-1] ? (~sample_q[INPUT_WIDTH-2:0] + ABS_ONE)
                                         : sample_q[INPUT_WIDTH-2:0]);
    peak_new  = (abs_val > peak_q[chan_q]) ? abs_val : peak_q[chan_q];
    cross_new = cross_q[chan_q];
    armed_new = armed_q[chan_q];
    if (sample_q <= NEG_HYST) begin
      armed_new = 1'b1;
    end else if (armed_q[chan_q] && !sample_q[INPUT_WIDTH-1]) begin
      armed_new = 1'b0;
      if (cross_q[chan_q] != CROSS_MAX) cross_new = cross_q[chan_q] + CROSS_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (m_fm_dv_q && m_fm_dr) m_fm_dv_d = 1'b0;
        if (s_sm_dv && s_sm_dr_q) begin
          sample_d = s_sm_d;
          chan_d   = s_sm_ch;
          state_d  = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
        if ({1'b0, chan_q} < NR_CH) begin
          armed_d[chan_q] = armed_new;
          if (count_q[chan_q] == COUNT_LAST) begin
            m_fm_f_d        = FREQUENCY_WIDTH'(cross_new) * RATIO;
            m_fm_peak_d     = peak_new;
            m_fm_ch_d       = chan_q;
            m_fm_dv_d       = 1'b1;
            count_d[chan_q] = '0;
            cross_d[chan_q] = '0;
            peak_d[chan_q]  = '0;
          end else begin
            count_d[chan_q] = count_q[chan_q] + COUNT_ONE;
            cross_d[chan_q] = cross_new;
            peak_d[chan_q]  = peak_new;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_sm_dr_d = (state_d == ST_IDLE) && !m_fm_dv_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_sm_dr_q   <= 1'b0;
      sample_q    <= '0;
      chan_q      <= '0;
      m_fm_f_q    <= '0;
      m_fm_peak_q <= '0;
      m_fm_ch_q   <= '0;
      m_fm_dv_q   <= 1'b0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
        armed_q[i] <= 1'b0;
        cross_q[i] <= '0;
        count_q[i] <= '0;
        peak_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      s_sm_dr_q   <= s_sm_dr_d;
      sample_q    <= sample_d;
      chan_q      <= chan_d;
      m_fm_f_q    <= m_fm_f_d;
      m_fm_peak_q <= m_fm_peak_d;
      m_fm_ch_q   <= m_fm_ch_d;
      m_fm_dv_q   <= m_fm_dv_d;
      for (int i = 0; i < NR_CHANNELS; i++) begin
        armed_q[i] <= armed_d[i];
        cross_q[i] <= cross_d[i];
        count_q[i] <= count_d[i];
        peak_q[i]  <= peak_d[i];
      end
    end
  end

  assign s_sm_dr   = s_sm_dr_q;
  assign m_fm_f    = m_fm_f_q;
  assign m_fm_peak = m_fm_peak_q;
  assign m_fm_ch   = m_fm_ch_q;
  assign m_fm_dv   = m_fm_dv_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_wave_meter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sine_wave_meter                                                       |
// | Randomised and directed self-checking bench for sine_wave_meter.        |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_sine_wave_meter;

  localparam int NCH   = 2;
  localparam int W     = 24;
  localparam int SF    = 48000;
  localparam int WIN   = 480;
  localparam int HYST  = 256;
  localparam int RATIO = SF / WIN;
  localparam int FULL  = (1 << (W - 1)) - 1;
  localparam int MINV  = -(1 << (W - 1));

  typedef struct { int f; int peak; int ch; } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  s_sm_d = '0;
  logic [0:0]    s_sm_ch = '0;
  logic          s_sm_dv = 1'b0;
  logic          s_sm_dr;
  logic [15:0]   m_fm_f;
  logic [W-2:0]  m_fm_peak;
  logic [0:0]    m_fm_ch;
  logic          m_fm_dv;
  logic          m_fm_dr = 1'b1;

  int t_run = 0;
  int t_fail = 0;

  int   m_armed [NCH];
  int   m_cross [NCH];
  int   m_count [NCH];
  int   m_peak  [NCH];
  res_t exp_q [$];
  res_t got_q [$];

  int n_sent = 0;
  int watch_first = 0;
  int first_sent = -1;
  int hold_req = 0;
  int hold_cnt = 0;
  int rand_dr = 0;

  sine_wave_meter #(
    .NR_CHANNELS(NCH), .INPUT_WIDTH(W), .SAMPLE_FREQUENCY(SF),
    .WINDOW_SAMPLES(WIN), .HYSTERESIS(HYST)
  ) dut (
    .clk(clk), .rst(rst),
    .s_sm_d(s_sm_d), .s_sm_ch(s_sm_ch), .s_sm_dv(s_sm_dv), .s_sm_dr(s_sm_dr),
    .m_fm_f(m_fm_f), .m_fm_peak(m_fm_peak), .m_fm_ch(m_fm_ch),
    .m_fm_dv(m_fm_dv), .m_fm_dr(m_fm_dr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    t_run++;
    if (got != want) begin
      t_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_armed[i] = 0; m_cross[i] = 0; m_count[i] = 0; m_peak[i] = 0;
    end
    exp_q.delete();
  endtask

  // Reference: frequency = rising crossings (armed below -HYST) per window * SF/WIN.
  task automatic model_update(input int ch, input int x);
    int   a;
    res_t r;
    a = (x == MINV) ? FULL : ((x < 0) ? -x : x);
    if (a > m_peak[ch]) m_peak[ch] = a;
    if (x <= -HYST) m_armed[ch] = 1;
    else if (m_armed[ch] != 0 && x >= 0) begin
      m_armed[ch] = 0;
      if (m_cross[ch] < 4095) m_cross[ch]++;
    end
    m_count[ch]++;
    if (m_count[ch] == WIN) begin
      r.f = m_cross[ch] * RATIO; r.peak = m_peak[ch]; r.ch = ch;
      exp_q.push_back(r);
      m_count[ch] = 0; m_cross[ch] = 0; m_peak[ch] = 0;
    end
  endtask

  task automatic send(input int ch, input int x);
    int guard;
    s_sm_ch = ch[0:0];
    s_sm_d  = x[W-1:0];
    s_sm_dv = 1'b1;
    guard   = 0;
    @(negedge clk);
    while (!s_sm_dr) begin
      guard++;
      if (guard > 300) begin
        check("accept_timeout", 0, 1);
        s_sm_dv = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    model_update(ch, x);
    n_sent++;
    #1 s_sm_dv = 1'b0;
  endtask

  function automatic int rand_sample();
    int u;
    case ($urandom_range(0, 3))
      0: begin u = int'($urandom_range(0, (1 << W) - 1)); return u + MINV; end
      1: return int'($urandom_range(0, 600)) - 300;
      2: begin
        case ($urandom_range(0, 7))
          0: return MINV;
          1: return FULL;
          2: return -HYST;
          3: return -HYST + 1;
          4: return 0;
          5: return -1;
          6: return HYST;
          default: return HYST - 1;
        endcase
      end
      default: return int'($urandom_range(0, 4000)) - 2000;
    endcase
  endfunction

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (hold_req != 0 && m_fm_dv) begin
      m_fm_dr = 1'b0;
      hold_cnt++;
      if (hold_cnt >= 50) hold_req = 0;
    end else if (rand_dr != 0) begin
      m_fm_dr = ($urandom_range(0, 2) != 0);
    end else begin
      m_fm_dr = 1'b1;
    end
  end

  int   prev_stall = 0;
  int   hs_prev = 0;
  int   streak = 0;
  res_t held;

  always @(negedge clk) begin
    res_t e;
    res_t g;
    if (rst) begin
      prev_stall = 0; hs_prev = 0; streak = 0;
    end else begin
      if (hs_prev != 0) check("dv_drop_after_handshake", int'(m_fm_dv), 0);
      hs_prev = 0;
      if (m_fm_dv) begin
        check("ready_low_while_result", int'(s_sm_dr), 0);
        if (prev_stall != 0) begin
          t_run++;
          if (int'(m_fm_f) != held.f || int'(m_fm_peak) != held.peak || int'(m_fm_ch) != held.ch) begin
            t_fail++;
            $display("FAIL hold_stable: got f=%0d peak=%0d ch=%0d, expected f=%0d peak=%0d ch=%0d",
                     m_fm_f, m_fm_peak, m_fm_ch, held.f, held.peak, held.ch);
          end
        end
        g.f = int'(m_fm_f); g.peak = int'(m_fm_peak); g.ch = int'(m_fm_ch);
        if (m_fm_dr) begin
          t_run++;
          if (exp_q.size() == 0) begin
            t_fail++;
            $display("FAIL unexpected_result: got f=%0d peak=%0d ch=%0d, expected none", g.f, g.peak, g.ch);
          end else begin
            e = exp_q.pop_front();
            if (g.f != e.f || g.peak != e.peak || g.ch != e.ch) begin
              t_fail++;
              $display("FAIL result: got f=%0d peak=%0d ch=%0d, expected f=%0d peak=%0d ch=%0d",
                       g.f, g.peak, g.ch, e.f, e.peak, e.ch);
            end
          end
          got_q.push_back(g);
          if (watch_first != 0) begin first_sent = n_sent; watch_first = 0; end
          hs_prev = 1;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          held = g;
        end
      end else begin
        prev_stall = 0;
      end
      if (exp_q.size() > 0 && !m_fm_dv) streak++;
      else streak = 0;
      if (streak == 2) check("result_latency", 0, 1);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    t_fail++;
    $display("[TB] %0d tests run, %0d failed", t_run, t_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #23;
    check("reset_s_sm_dr", int'(s_sm_dr), 0);
    check("reset_m_fm_dv", int'(m_fm_dv), 0);
    check("reset_outputs", int'(m_fm_f) + int'(m_fm_peak) + int'(m_fm_ch), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", int'(s_sm_dr), 1);

    // Constant zero: three windows per channel.
    got_q.delete();
    for (int i = 0; i < 3 * 2 * WIN; i++) send(i % 2, 0);
    drain();
    check("zero_result_count", got_q.size(), 6);
    for (int i = 0; i < got_q.size(); i++) begin
      check("zero_f", got_q[i].f, 0);
      check("zero_peak", got_q[i].peak, 0);
      check("zero_ch", got_q[i].ch, i % 2);
    end

    // Single most-negative sample on ch1, followed by zeros.
    got_q.delete();
    for (int i = 0; i < WIN; i++) begin
      send(0, 0);
      send(1, (i == 0) ? MINV : 0);
    end
    drain();
    check("min_result_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("min_ch0_peak", got_q[0].peak, 0);
      check("min_ch1_peak_sat", got_q[1].peak, 8388607);
      check("min_ch1_f", got_q[1].f, 100);
    end

    // 1000 Hz square +/-1000 on ch0, +/-100 (inside hysteresis) on ch1.
    got_q.delete();
    for (int k = 0; k < 2 * WIN; k++) begin
      send(0, ((k % 48) < 24) ? 1000 : -1000);
      send(1, ((k % 48) < 24) ? 100 : -100);
    end
    drain();
    check("sq_result_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("sq_ch0_first_f", got_q[0].f, 900);
      check("sq_ch0_peak", got_q[0].peak, 1000);
      check("sq_ch1_f", got_q[1].f, 0);
      check("sq_ch1_peak", got_q[1].peak, 100);
      check("sq_ch0_second_f", got_q[2].f, 1000);
      check("sq_ch1_second_f", got_q[3].f, 0);
    end

    // Stall the first result of this window for 50 clocks.
    hold_cnt = 0;
    hold_req = 1;
    for (int i = 0; i < 2 * WIN; i++) send(i % 2, rand_sample());
    drain();
    check("hold_cycles", hold_cnt, 50);

    // Random channels, values, gaps and output back-pressure.
    rand_dr = 1;
    for (int i = 0; i < 3000; i++) begin
      send(int'($urandom_range(0, 1)), rand_sample());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_dr = 0;
    drain();
    check("queue_empty_after_random", exp_q.size(), 0);

    // Reset in the middle of a window.
    for (int i = 0; i < 4 * WIN && m_count[0] != 200; i++) send(i % 2, rand_sample());
    check("pre_reset_count", m_count[0], 200);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dv", int'(m_fm_dv), 0);
    check("async_rst_dr", int'(s_sm_dr), 0);
    check("async_rst_outputs", int'(m_fm_f) + int'(m_fm_peak) + int'(m_fm_ch), 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_sent = 0;
    first_sent = -1;
    watch_first = 1;
    got_q.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 2 * WIN; i++) send(i % 2, rand_sample());
    drain();
    check("post_reset_first_result_at", first_sent, 2 * WIN - 1);
    check("post_reset_result_count", got_q.size(), 2);
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", t_run, t_fail);
    $finish;
  end

endmodule
`default_nettype wire
